// File: rtl/up_down_count_sequencer.sv
// up_down_count_sequencer
// Bounded up/down/ping-pong counter sequencer with start/hold/abort control,
// busy/done/err status and asynchronous active-low reset on clr.
module up_down_count_sequencer #(
  parameter int WIDTH  = 3,
  parameter int PASS_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  input  logic [1:0]        mode,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [PASS_W-1:0] passes,
  output logic [WIDTH-1:0]  Q,
  output logic              m,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;

  state_t              r_state;
  logic [WIDTH-1:0]    r_q;
  logic                r_m;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [WIDTH-1:0]    r_lo;
  logic [WIDTH-1:0]    r_hi;
  logic [1:0]          r_mode;
  logic [PASS_W-1:0]   r_passes;
  logic [PASS_W-1:0]   r_pass_cnt;

  logic [PASS_W-1:0]   w_pass_next;
  logic                w_pingpong;
  logic                w_last_pass;
  logic                w_up_finish;
  logic                w_down_finish;

  // Endpoint decisions: which endpoints end the sequence rather than reverse it
  always_comb begin
    w_pass_next   = r_pass_cnt + PASS_W'(1);
    w_pingpong    = (r_mode == MODE_PING);
    w_last_pass   = (w_pass_next == r_passes);
    w_up_finish   = !w_pingpong || w_last_pass;
    w_down_finish = (r_mode == MODE_DOWN) || (w_pingpong && w_last_pass);
  end

  // Sequencer FSM with registered count, direction and status outputs
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state    <= S_IDLE;
      r_q        <= '0;
      r_m        <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_lo       <= '0;
      r_hi       <= '0;
      r_mode     <= '0;
      r_passes   <= '0;
      r_pass_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          if (start) begin
            if (lo > hi) begin
              r_err <= 1'b1;
            end else begin
              r_lo       <= lo;
              r_hi       <= hi;
              r_mode     <= mode;
              r_passes   <= (passes == '0) ? PASS_W'(1) : passes;
              r_pass_cnt <= '0;
              r_busy     <= 1'b1;
              if (mode == MODE_DOWN) begin
                r_q     <= hi;
                r_m     <= 1'b1;
                r_state <= S_DOWN;
              end else begin
                r_q     <= lo;
                r_m     <= 1'b0;
                r_state <= S_UP;
              end
            end
          end
        end

        S_UP: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!hold) begin
            if (r_q < r_hi) begin
              r_q <= r_q + WIDTH'(1);
            end else begin
              r_pass_cnt <= w_pass_next;
              if (w_up_finish) begin
                r_state <= S_DONE;
              end else begin
                r_m     <= 1'b1;
                r_state <= S_DOWN;
              end
            end
          end
        end

        S_DOWN: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!hold) begin
            if (r_q > r_lo) begin
              r_q <= r_q - WIDTH'(1);
            end else begin
              r_pass_cnt <= w_pass_next;
              if (w_down_finish) begin
                r_state <= S_DONE;
              end else begin
                r_m     <= 1'b0;
                r_state <= S_UP;
              end
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs come straight from registers
  always_comb begin
    Q    = r_q;
    m    = r_m;
    busy = r_busy;
    done = r_done;
    err  = r_err;
  end

endmodule

// File: tb/tb_up_down_count_sequencer.sv
// Testbench for up_down_count_sequencer: queue-based scoreboard fed by a
// plan-building reference model, directed scenarios then random traffic.
module tb_up_down_count_sequencer;

  localparam int WIDTH  = 3;
  localparam int PASS_W = 4;

  logic              clk = 1'b0;
  logic              clr;
  logic              start;
  logic              abort;
  logic              hold;
  logic [1:0]        mode;
  logic [WIDTH-1:0]  lo;
  logic [WIDTH-1:0]  hi;
  logic [PASS_W-1:0] passes;
  logic [WIDTH-1:0]  Q;
  logic              m;
  logic              busy;
  logic              done;
  logic              err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             m;
    logic             busy;
    logic             done;
    logic             err;
  } obs_t;

  obs_t sb[$];     // expected outputs after each upcoming edge
  obs_t plan[$];   // remaining outputs of the active sequence
  obs_t cur;       // model's view of the current outputs

  up_down_count_sequencer #(.WIDTH(WIDTH), .PASS_W(PASS_W)) dut (
    .clk(clk), .clr(clr), .start(start), .abort(abort), .hold(hold),
    .mode(mode), .lo(lo), .hi(hi), .passes(passes),
    .Q(Q), .m(m), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Lay out the whole output sequence of an accepted start, one entry per edge
  task automatic build_plan(input int mo, input int l, input int h, input int p);
    int ns;
    int q;
    logic d;
    ns = (mo == 2) ? ((p == 0) ? 1 : p) : 1;
    d  = (mo == 1);
    q  = d ? h : l;
    plan.delete();
    plan.push_back('{q: WIDTH'(q), m: d, busy: 1'b1, done: 1'b0, err: 1'b0});
    for (int s = 0; s < ns; s++) begin
      while (q != (d ? l : h)) begin
        q = d ? q - 1 : q + 1;
        plan.push_back('{q: WIDTH'(q), m: d, busy: 1'b1, done: 1'b0, err: 1'b0});
      end
      if (s == ns - 1) begin
        plan.push_back('{q: WIDTH'(q), m: d, busy: 1'b1, done: 1'b0, err: 1'b0});
        plan.push_back('{q: WIDTH'(q), m: d, busy: 1'b0, done: 1'b1, err: 1'b0});
      end else begin
        d = !d;
        plan.push_back('{q: WIDTH'(q), m: d, busy: 1'b1, done: 1'b0, err: 1'b0});
      end
    end
  endtask

  // Apply inputs for the next edge and record what that edge should produce
  task automatic drive_and_push(input int st, input int ab, input int ho,
                                input int mo, input int l, input int h, input int p);
    obs_t e;
    start  = (st != 0);
    abort  = (ab != 0);
    hold   = (ho != 0);
    mode   = 2'(mo);
    lo     = WIDTH'(l);
    hi     = WIDTH'(h);
    passes = PASS_W'(p);
    if (plan.size() == 0) begin
      e = cur;
      e.busy = 1'b0;
      e.done = 1'b0;
      e.err  = 1'b0;
      if (st != 0) begin
        if (l > h) begin
          e.err = 1'b1;
        end else begin
          build_plan(mo, l, h, p);
          e = plan.pop_front();
        end
      end
    end else if (plan.size() == 1) begin
      e = plan.pop_front();        // completion cycle: controls have no effect
    end else if (ab != 0) begin
      plan.delete();
      e = cur;
      e.busy = 1'b0;
    end else if (ho != 0) begin
      e = cur;
    end else begin
      e = plan.pop_front();
    end
    cur = e;
    sb.push_back(e);
  endtask

  task automatic step(input int st, input int ab, input int ho,
                      input int mo, input int l, input int h, input int p);
    @(negedge clk);
    #1;
    drive_and_push(st, ab, ho, mo, l, h, p);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Pull clr low between edges, check the immediate clear, then release
  task automatic do_reset();
    @(negedge clk);
    #1 clr = 1'b0;
    #1;
    chk("rst_Q", int'(Q), 0);
    chk("rst_m", int'(m), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    #1 clr = 1'b1;
    plan.delete();
    cur = '0;
    drive_and_push(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every edge's outputs are compared against the next expectation
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{q: Q, m: m, busy: busy, done: done, err: err};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL out t=%0t actual Q=%0d m=%0b busy=%0b done=%0b err=%0b required Q=%0d m=%0b busy=%0b done=%0b err=%0b",
                   $time, a.q, a.m, a.busy, a.done, a.err, e.q, e.m, e.busy, e.done, e.err);
        end
      end
    end
  end

  initial begin
    int drain;
    clr = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0;
    mode = '0; lo = '0; hi = '0; passes = '0;
    cur = '0;
    repeat (2) @(posedge clk);
    do_reset();

    // up 2..5
    step(1, 0, 0, 0, 2, 5, 0); idle(8);
    // ping-pong 1..3, two passes; then passes=0
    step(1, 0, 0, 2, 1, 3, 2); idle(10);
    step(1, 0, 0, 2, 1, 3, 0); idle(6);
    // down 0..7, then lo==hi down
    step(1, 0, 0, 1, 0, 7, 0); idle(12);
    step(1, 0, 0, 1, 4, 4, 0); idle(4);
    // lo==hi up
    step(1, 0, 0, 3, 6, 6, 5); idle(4);
    // rejected bounds
    step(1, 0, 0, 0, 6, 2, 0); idle(2);
    // start mid-sequence is ignored, including under hold
    step(1, 0, 0, 0, 0, 7, 0); idle(2);
    step(1, 0, 0, 2, 1, 2, 3);
    step(1, 0, 1, 1, 5, 6, 3); idle(10);
    // hold at 3 then abort together with hold at 4
    step(1, 0, 0, 0, 0, 7, 0); idle(3);
    repeat (3) step(0, 0, 1, 0, 0, 0, 0);
    idle(1);
    step(0, 1, 1, 0, 0, 0, 0); idle(3);
    // abort in down direction of ping-pong
    step(1, 0, 0, 2, 2, 4, 3); idle(4);
    step(0, 1, 0, 0, 0, 0, 0); idle(2);
    // clr mid-count, then a fresh start
    step(1, 0, 0, 0, 0, 7, 0); idle(3);
    do_reset();
    step(1, 0, 0, 0, 1, 2, 0); idle(6);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 3) == 0) ? 1 : 0,
             ($urandom_range(0, 24) == 0) ? 1 : 0,
             ($urandom_range(0, 4) == 0) ? 1 : 0,
             int'($urandom_range(0, 3)),
             int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)),
             int'($urandom_range(0, 3)));
      end
    end
    idle(40);

    drain = 0;
    while (sb.size() > 0 && drain < 20) begin
      @(negedge clk);
      drain++;
    end
    @(negedge clk);
    chk("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
